fetch_unit: RTL

Instruction fetch stage with a small prefetch queue. It sits directly upstream of `decoder`. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered in a FIFO and presented to the decode stage, together with their PC, over a valid/ready handshake. A flush input redirects fetch on a branch or PC write and discards stale words, including any read already in flight.

---
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage with a small prefetch queue, feeding the decoder.
// Owns the fetch PC, issues one word read at a time to instruction memory
// (req/ack), buffers returned words with their PC tag in a FIFO and presents
// the head entry to decode (valid/ready). A flush redirects fetch, empties the
// queue and discards any read still in flight.
//
// Optional feature macro: FETCH_PC_PLUS8_EN
//   defined   : instr_pc = fetch address + 8 (mod 2^32)
//   undefined : instr_pc = fetch address of the word
//
// Ports:
//   clk1        in   clock, rising edge
//   rst         in   synchronous active-high reset
//   mem_req     out  read request outstanding
//   mem_addr    out  word address of the outstanding request
//   mem_ack     in   memory accepts request, mem_rdata valid this cycle
//   mem_rdata   in   instruction word
//   instr_valid out  head entry valid
//   instr_ready in   decode consumes head entry
//   instr       out  head instruction word
//   instr_pc    out  head PC tag
//   flush       in   redirect fetch
//   flush_addr  in   redirect address (bits [1:0] ignored)
//   q_count     out  queue occupancy
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                   clk1,
    input  logic                   rst,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    input  logic                   flush,
    input  logic [31:0]            flush_addr,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef FETCH_PC_PLUS8_EN
    localparam logic [31:0] TAG_OFS = 32'd8;
`else
    localparam logic [31:0] TAG_OFS = 32'd0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_e          state_q,    state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    entry_t          fifo_q [DEPTH];

    logic            push_c;
    logic            pop_c;
    logic [CW-1:0]   count_next_c;
    logic            has_room_c;
    logic [31:0]     flush_pc_c;
    logic            flush_addr_unused;

    assign flush_pc_c        = {flush_addr[31:2], 2'b00};
    assign flush_addr_unused = ^flush_addr[1:0];

    // Queue handshakes; a flush overrides both push and pop
    assign push_c       = (state_q == S_REQ) && mem_ack && !flush;
    assign pop_c        = instr_valid && instr_ready && !flush;
    assign count_next_c = count_q + CW'(push_c) - CW'(pop_c);
    assign has_room_c   = count_next_c < CW'(DEPTH);

    // Outputs decoded from registered state only
    assign mem_req     = (state_q != S_IDLE);
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? fifo_q[rd_ptr_q].word : 32'd0;
    assign instr_pc    = instr_valid ? fifo_q[rd_ptr_q].pc   : 32'd0;
    assign q_count     = count_q;

    // Queue pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_next_c;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Fetch FSM. In REQ, mem_addr_q equals fetch_pc_q; in DROP, fetch_pc_q
    // holds the redirect target while mem_addr_q keeps the stale address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        if (flush) begin
            fetch_pc_d = flush_pc_c;
            case (state_q)
                S_IDLE: begin
                    state_d    = S_REQ;
                    mem_addr_d = flush_pc_c;
                end
                S_REQ, S_DROP: begin
                    if (mem_ack) begin
                        state_d    = S_REQ;
                        mem_addr_d = flush_pc_c;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (has_room_c) begin
                        state_d    = S_REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (has_room_c) begin
                            mem_addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        if (has_room_c) begin
                            state_d    = S_REQ;
                            mem_addr_d = fetch_pc_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= {RESET_ADDR[31:2], 2'b00};
            mem_addr_q <= 32'd0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; tag is the requested address (plus offset when enabled)
    always_ff @(posedge clk1) begin
        if (push_c && !rst) begin
            fifo_q[wr_ptr_q] <= '{pc: mem_addr_q + TAG_OFS, word: mem_rdata};
        end
    end

endmodule
